// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader:
// state encoding, header/word byte counts and the header range check.
package instr_mem_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_LEN_HI  = 3'd1;
  localparam state_t ST_LEN_LO  = 3'd2;
  localparam state_t ST_DATA_HI = 3'd3;
  localparam state_t ST_DATA_LO = 3'd4;
  localparam state_t ST_FLUSH   = 3'd5;
  localparam state_t ST_DONE    = 3'd6;
  localparam state_t ST_ERR     = 3'd7;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 2;
  localparam int CNT_W          = 8 * HDR_BYTES;

  // A header is usable when the word count does not exceed the memory depth;
  // the comparison is one bit wider so depth == 2**CNT_W is representable.
  function automatic logic count_fits(input logic [CNT_W-1:0] count, input int addr_w);
    logic [CNT_W:0] depth;
    depth = {{CNT_W{1'b0}}, 1'b1} << addr_w;
    return {1'b0, count} <= depth;
  endfunction

endpackage

// File: rtl/instr_mem_loader.sv
// Streams a length-prefixed big-endian image into instruction memory from
// address 0 and holds the processor in reset until the image is complete.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int W      = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [W-1:0]      mem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int HOLD_W = 8 * (BYTES_PER_WORD - 1);
  localparam int CMP_W  = CNT_W + 1;

  state_t            state_reg;
  state_t            state_next;
  logic [CNT_W-1:0]  count_reg;
  logic [ADDR_W:0]   idx_reg;
  logic [HOLD_W-1:0] hold_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [W-1:0]      mem_wdata_reg;

  logic              xfer;
  logic [CNT_W-1:0]  count_full;
  logic              last_word;

  assign xfer       = in_valid && in_ready;
  assign count_full = {count_reg[CNT_W-1:8], in_data};
  // Index is compared one bit wider than the count so count == depth works.
  assign last_word  = (CMP_W'(idx_reg) == ({1'b0, count_reg} - CMP_W'(1)));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (start) state_next = ST_LEN_HI;
      ST_LEN_HI:  if (xfer)  state_next = ST_LEN_LO;
      ST_LEN_LO: begin
        if (xfer) begin
          if (count_full == '0)
            state_next = ST_DONE;
          else if (!count_fits(count_full, ADDR_W))
            state_next = ST_ERR;
          else
            state_next = ST_DATA_HI;
        end
      end
      ST_DATA_HI: if (xfer) state_next = ST_DATA_LO;
      ST_DATA_LO: if (xfer) state_next = last_word ? ST_FLUSH : ST_DATA_HI;
      ST_FLUSH:   state_next = ST_DONE;
      ST_DONE:    if (start) state_next = ST_LEN_HI;
      ST_ERR:     if (start) state_next = ST_LEN_HI;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      count_reg     <= '0;
      idx_reg       <= '0;
      hold_reg      <= '0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      state_reg  <= state_next;
      mem_we_reg <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) idx_reg <= '0;
        end
        ST_LEN_HI: begin
          if (xfer) count_reg[CNT_W-1:8] <= in_data;
        end
        ST_LEN_LO: begin
          if (xfer) count_reg[7:0] <= in_data;
        end
        ST_DATA_HI: begin
          if (xfer) hold_reg <= in_data;
        end
        ST_DATA_LO: begin
          // The write lands one cycle after the low byte, never back to back.
          if (xfer) begin
            mem_we_reg    <= 1'b1;
            mem_addr_reg  <= idx_reg[ADDR_W-1:0];
            mem_wdata_reg <= W'({hold_reg, in_data});
            idx_reg       <= idx_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Status decodes straight from the state register so reset shows at once.
  assign in_ready  = (state_reg == ST_LEN_HI) || (state_reg == ST_LEN_LO) ||
                     (state_reg == ST_DATA_HI) || (state_reg == ST_DATA_LO);
  assign busy      = in_ready || (state_reg == ST_FLUSH);
  assign done      = (state_reg == ST_DONE);
  assign error     = (state_reg == ST_ERR);
  assign cpu_rst   = (state_reg != ST_DONE);
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: images are modelled as byte lists,
// expected writes are queued up front and a monitor checks each mem_we.
module tb_instr_mem_loader;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              error;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } wr_t;
  typedef logic [7:0] bytes_t[$];

  wr_t  exp_q[$];
  wr_t  mon_e;
  int   checks = 0;
  int   errors = 0;
  logic prev_we = 1'b0;

  instr_mem_loader #(.W(16), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst) begin
      prev_we = 1'b0;
    end else begin
      if (mem_we) begin
        chk("we_back_to_back", prev_we, 0);
        chk("cpu_rst_during_write", cpu_rst, 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", mem_addr, mon_e.addr);
          chk("wr_data", mem_wdata, mon_e.data);
          $display("write addr %0h data %04h", mem_addr, mem_wdata);
        end
      end
      prev_we = mem_we;
    end
  end

  function automatic int hdr_count(input bytes_t b);
    return {b[0], b[1]};
  endfunction

  // Reference: header word count, then big-endian pairs to addresses 0..count-1.
  task automatic model(input bytes_t b);
    int  cnt;
    wr_t w;
    cnt = hdr_count(b);
    if (cnt <= DEPTH) begin
      for (int i = 0; i < cnt; i++) begin
        w.addr = ADDR_W'(i);
        w.data = {b[2 + 2 * i], b[3 + 2 * i]};
        exp_q.push_back(w);
      end
    end
  endtask

  function automatic bytes_t make_image(input int cnt, input int nwords);
    bytes_t b;
    logic [15:0] c;
    c = 16'(cnt);
    b.push_back(c[15:8]);
    b.push_back(c[7:0]);
    for (int i = 0; i < 2 * nwords; i++) b.push_back(8'($urandom));
    return b;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ready_after_start", in_ready, 1);
    chk("cpu_rst_after_start", cpu_rst, 1);
    chk("busy_after_start", busy, 1);
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send_byte(input logic [7:0] v, input int max_gap);
    int gap;
    int n;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      @(negedge clk);
      chk("ready_held_in_gap", in_ready, 1);
    end
    in_valid = 1'b1;
    in_data  = v;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got in_ready 0 expected 1 within 20 cycles");
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
  endtask

  task automatic finish_load(input int cnt);
    if (cnt == 0) begin
      chk("empty_done", done, 1);
      chk("empty_cpu_rst", cpu_rst, 0);
      chk("empty_no_write", mem_we, 0);
    end else if (cnt > DEPTH) begin
      chk("err_flag", error, 1);
      chk("err_ready", in_ready, 0);
      chk("err_cpu_rst", cpu_rst, 1);
      chk("err_busy", busy, 0);
    end else begin
      chk("flush_busy", busy, 1);
      chk("flush_ready", in_ready, 0);
      chk("flush_done", done, 0);
      chk("flush_cpu_rst", cpu_rst, 1);
      @(negedge clk);
      chk("done_flag", done, 1);
      chk("done_cpu_rst", cpu_rst, 0);
      chk("done_busy", busy, 0);
    end
    chk("writes_pending", exp_q.size(), 0);
    $display("load count %0d: done=%0b error=%0b cpu_rst=%0b", cnt, done, error, cpu_rst);
  endtask

  task automatic run_image(input bytes_t b, input int max_gap);
    int cnt;
    int n;
    cnt = hdr_count(b);
    n = (cnt > DEPTH) ? 2 : b.size();
    model(b);
    pulse_start();
    for (int i = 0; i < n; i++) send_byte(b[i], max_gap);
    in_valid = 1'b0;
    finish_load(cnt);
  endtask

  bytes_t      img;
  logic [63:0] fixed_img;

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_we", mem_we, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", in_ready, 0);

    // Fixed 3-word image, streaming and with random gaps
    fixed_img = 64'h0003_1460_2801_FFFF;
    img = {};
    for (int i = 0; i < 8; i++) img.push_back(fixed_img[63 - 8 * i -: 8]);
    run_image(img, 0);
    run_image(img, 5);

    run_image(make_image(0, 0), 0);
    run_image(make_image(17, 0), 0);
    run_image(make_image(16, 16), 3);

    // start during DATA_HI must not restart the load
    img = make_image(3, 3);
    model(img);
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(img[i], 0);
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign_start_busy", busy, 1);
    chk("ign_start_ready", in_ready, 1);
    for (int i = 4; i < 8; i++) send_byte(img[i], 0);
    in_valid = 1'b0;
    finish_load(3);

    // Reset in the middle of a word: immediate reset values, no write
    img = make_image(2, 2);
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte(img[i], 0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cpu_rst", cpu_rst, 1);
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_wdata", mem_wdata, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle_ready", in_ready, 0);
    chk("post_rst_no_write", exp_q.size(), 0);
    run_image(make_image(2, 2), 0);

    for (int k = 0; k < 6; k++) begin
      int c;
      c = int'($urandom_range(DEPTH, 1));
      run_image(make_image(c, c), int'($urandom_range(3, 0)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
